button_debouncer: RTL and testbench

//  Cleans a raw, asynchronous, bouncing input (push-button or switch) into a single-clock,

---
 rtl/button_debouncer_pkg.sv | 19 +
 rtl/button_debouncer_if.sv | 17 +
 rtl/button_debouncer_sync_nff.sv | 23 ++
 rtl/button_debouncer.sv | 118 +++++++++++
 tb/tb_button_debouncer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the button debouncer: FSM encoding and size constants.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_CNT_WIDTH     = 20;

  function automatic logic is_wait(deb_state_e s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between a raw input source and the debouncer.
// Edge strobes exist only when DEB_EDGE_PULSE_EN is defined.
interface button_debouncer_if;
  logic din_raw;
  logic db_out;
  logic busy;
`ifdef DEB_EDGE_PULSE_EN
  logic rise;
  logic fall;

  modport master (output din_raw, input db_out, input busy, input rise, input fall);
  modport slave  (input din_raw, output db_out, output busy, output rise, output fall);
`else
  modport master (output din_raw, input db_out, input busy);
  modport slave  (input din_raw, output db_out, output busy);
`endif
endinterface

// File: rtl/button_debouncer_sync_nff.sv
// N-flop synchronizer with synchronous active-high reset to 0; shared by input stages.
module sync_nff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  assign sync_d = {sync_q[N-2:0], d_i};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/button_debouncer.sv
// Debouncer: synchronizer, stability-counter FSM, registered level and optional edge strobes.
// Define DEB_EDGE_PULSE_EN to build the rise/fall strobe outputs.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  button_debouncer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic din_s;

  sync_nff #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.din_raw),
    .q_o (din_s)
  );

  deb_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 db_q,    db_d;

  // Any disagreement with the candidate level drops back to IDLE with no partial credit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    case (state_q)
      IDLE_LO: begin
        if (din_s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!din_s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          db_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!din_s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (din_s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          db_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign bus.db_out = db_q;
  assign bus.busy   = is_wait(state_q);

`ifdef DEB_EDGE_PULSE_EN
  // Strobes are registered alongside db_q, so they sit high for the cycle after the toggle.
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  assign rise_d = !db_q &&  db_d;
  assign fall_d =  db_q && !db_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, STABLE_CYCLES=8, CNT_WIDTH=4.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  button_debouncer_if bus ();

  button_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .CNT_WIDTH     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scenario 1: held reset with din_raw=1, then qualification of the rising level.
  task automatic test_reset();
    logic exp_db, exp_busy, exp_rise;
    rst = 1'b1;
    bus.din_raw = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (bus.db_out !== 1'b0) begin errors++; $display("FAIL rst_db t=%0d got=%b exp=0", t, bus.db_out); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy t=%0d got=%b exp=0", t, bus.busy); end
`ifdef DEB_EDGE_PULSE_EN
      checks++;
      if (bus.rise !== 1'b0 || bus.fall !== 1'b0) begin
        errors++; $display("FAIL rst_strobe t=%0d got=%b%b exp=00", t, bus.rise, bus.fall);
      end
`endif
    end
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp_db   = (t >= 10);
      exp_busy = (t >= 3) && (t <= 9);
      exp_rise = (t == 10);
      checks++;
      if (bus.db_out !== exp_db) begin errors++; $display("FAIL rise_db t=%0d got=%b exp=%b", t, bus.db_out, exp_db); end
      checks++;
      if (bus.busy !== exp_busy) begin errors++; $display("FAIL rise_busy t=%0d got=%b exp=%b", t, bus.busy, exp_busy); end
`ifdef DEB_EDGE_PULSE_EN
      checks++;
      if (bus.rise !== exp_rise) begin errors++; $display("FAIL rise_strobe t=%0d got=%b exp=%b", t, bus.rise, exp_rise); end
      checks++;
      if (bus.fall !== 1'b0) begin errors++; $display("FAIL rise_nofall t=%0d got=%b exp=0", t, bus.fall); end
`endif
    end
  endtask

  // Scenario 2: clean 1->0 step from settled high; db_out and busy must match in both builds.
  task automatic test_clean_fall();
    logic exp_db, exp_busy, exp_fall;
    bus.din_raw = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp_db   = (t < 10);
      exp_busy = (t >= 3) && (t <= 9);
      exp_fall = (t == 10);
      checks++;
      if (bus.db_out !== exp_db) begin errors++; $display("FAIL fall_db t=%0d got=%b exp=%b", t, bus.db_out, exp_db); end
      checks++;
      if (bus.busy !== exp_busy) begin errors++; $display("FAIL fall_busy t=%0d got=%b exp=%b", t, bus.busy, exp_busy); end
`ifdef DEB_EDGE_PULSE_EN
      checks++;
      if (bus.fall !== exp_fall) begin errors++; $display("FAIL fall_strobe t=%0d got=%b exp=%b", t, bus.fall, exp_fall); end
      checks++;
      if (bus.rise !== 1'b0) begin errors++; $display("FAIL fall_norise t=%0d got=%b exp=0", t, bus.rise); end
`endif
    end
  endtask

  // Scenario 3: din_raw 1,0,1,0 for 3 cycles each, then holds 1; last change sampled at t=13.
  task automatic test_bounce();
    logic exp_db, exp_busy, exp_rise;
    for (int t = 1; t <= 24; t++) begin
      bus.din_raw = (t > 12) || ((((t - 1) / 3) % 2) == 0);
      tick();
      exp_db   = (t >= 22);
      exp_busy = (t >= 3 && t <= 5) || (t >= 9 && t <= 11) || (t >= 15 && t <= 21);
      exp_rise = (t == 22);
      checks++;
      if (bus.db_out !== exp_db) begin errors++; $display("FAIL bounce_db t=%0d got=%b exp=%b", t, bus.db_out, exp_db); end
      checks++;
      if (bus.busy !== exp_busy) begin errors++; $display("FAIL bounce_busy t=%0d got=%b exp=%b", t, bus.busy, exp_busy); end
`ifdef DEB_EDGE_PULSE_EN
      checks++;
      if (bus.rise !== exp_rise) begin errors++; $display("FAIL bounce_rise t=%0d got=%b exp=%b", t, bus.rise, exp_rise); end
      checks++;
      if (bus.fall !== 1'b0) begin errors++; $display("FAIL bounce_fall t=%0d got=%b exp=0", t, bus.fall); end
`endif
    end
  endtask

  // Scenario 4: a 7-cycle high glitch, one short of qualifying, from a settled low level.
  task automatic test_glitch();
    logic exp_busy;
    bus.din_raw = 1'b0;
    for (int t = 1; t <= 12; t++) tick();
    checks++;
    if (bus.db_out !== 1'b0) begin errors++; $display("FAIL glitch_setup_db got=%b exp=0", bus.db_out); end
    for (int t = 1; t <= 14; t++) begin
      bus.din_raw = (t <= 7);
      tick();
      exp_busy = (t >= 3) && (t <= 9);
      checks++;
      if (bus.db_out !== 1'b0) begin errors++; $display("FAIL glitch_db t=%0d got=%b exp=0", t, bus.db_out); end
      checks++;
      if (bus.busy !== exp_busy) begin errors++; $display("FAIL glitch_busy t=%0d got=%b exp=%b", t, bus.busy, exp_busy); end
`ifdef DEB_EDGE_PULSE_EN
      checks++;
      if (bus.rise !== 1'b0) begin errors++; $display("FAIL glitch_rise t=%0d got=%b exp=0", t, bus.rise); end
`endif
    end
  endtask

  // Scenario 5: reset while WAIT_HI holds cnt=5, then a full requalification.
  task automatic test_reset_mid_qual();
    logic exp_db, exp_busy;
    bus.din_raw = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_busy = (t >= 3);
      checks++;
      if (bus.busy !== exp_busy) begin errors++; $display("FAIL midrst_pre_busy t=%0d got=%b exp=%b", t, bus.busy, exp_busy); end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.db_out !== 1'b0) begin errors++; $display("FAIL midrst_db got=%b exp=0", bus.db_out); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp_db   = (t >= 10);
      exp_busy = (t >= 3) && (t <= 9);
      checks++;
      if (bus.db_out !== exp_db) begin errors++; $display("FAIL midrst_requal_db t=%0d got=%b exp=%b", t, bus.db_out, exp_db); end
      checks++;
      if (bus.busy !== exp_busy) begin errors++; $display("FAIL midrst_requal_busy t=%0d got=%b exp=%b", t, bus.busy, exp_busy); end
    end
  endtask

  initial begin
    bus.din_raw = 1'b0;
    test_reset();
    test_clean_fall();
    test_bounce();
    test_glitch();
    test_reset_mid_qual();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
